// File: rtl/wb_pipe_responder_if.sv
// Pipelined Wishbone-style bus between one master and the wb_pipe_responder.
//   addr_i  : byte address            data_i : write data
//   sel_i   : byte enables            we_i   : 1 = write, 0 = read
//   stb_i   : request strobe          cyc_i  : bus cycle active
//   stall_o : request not accepted    ack_o  : one-cycle response
//   data_o  : read data, valid with ack_o
// Signal names carry the responder's point of view (_i into it, _o out of it).
interface wb_pipe_responder_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        stb_i;
  logic        cyc_i;
  logic        stall_o;
  logic        ack_o;
  logic [31:0] data_o;

  modport master (
    output addr_i, data_i, sel_i, we_i, stb_i, cyc_i,
    input  stall_o, ack_o, data_o
  );

  modport slave (
    input  addr_i, data_i, sel_i, we_i, stb_i, cyc_i,
    output stall_o, ack_o, data_o
  );
endinterface

// File: rtl/wb_pipe_responder.sv
// Pipelined Wishbone responder backed by a 2^ADDR_W x 32-bit memory.
// Requests are accepted when cyc_i & stb_i & !stall_o. Writes commit and reads
// sample the memory at the accept edge; each request then travels down a
// LATENCY-stage pipeline and is acknowledged in order from its last stage.
// stall_o rises when DEPTH requests are outstanding or when the LFSR-driven
// random stall fires (STALL_RATE/16 of cycles; 0 disables it).
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous, active-low reset
//   bus   : slave side of wb_pipe_responder_if
module wb_pipe_responder #(
  parameter int          ADDR_W     = 10,
  parameter int          LATENCY    = 2,
  parameter int          DEPTH      = 4,
  parameter int          STALL_RATE = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_pipe_responder_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WORDS = 1 << ADDR_W;

  logic [31:0]        mem [WORDS];
  logic [ADDR_W-1:0]  word_idx;
  logic               accept;
  logic               ack;
  logic [LATENCY-1:0] pipe_vld;
  logic [31:0]        pipe_dat [LATENCY];
  logic [CNT_W-1:0]   outstanding;
  logic [15:0]        lfsr;
  logic               rnd_stall;
  logic               unused_addr;

  // Addresses wrap modulo the memory size; byte-offset and high bits are ignored.
  assign word_idx    = bus.addr_i[ADDR_W+1:2];
  assign unused_addr = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

  assign bus.stall_o = (outstanding == CNT_W'(DEPTH)) || rnd_stall;
  assign accept      = bus.cyc_i && bus.stb_i && !bus.stall_o;

  // A request reaching the last stage while the master has dropped cyc_i is
  // abandoned, so the ack is masked combinationally as well as flushed.
  assign ack         = pipe_vld[LATENCY-1] && bus.cyc_i;
  assign bus.ack_o   = ack;
  assign bus.data_o  = ack ? pipe_dat[LATENCY-1] : 32'h0;

  // NOTE: the memory and the data half of the pipeline have no reset; data is
  // only observed when its valid bit is set, and valids are reset below.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      if (bus.we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.sel_i[b]) mem[word_idx][8*b +: 8] <= bus.data_i[8*b +: 8];
        end
        pipe_dat[0] <= 32'h0;
      end else begin
        pipe_dat[0] <= mem[word_idx];
      end
    end
    for (int i = 1; i < LATENCY; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pipe_vld    <= '0;
      outstanding <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      // Fibonacci LFSR, taps 16,14,13,11.
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (!bus.cyc_i) begin
        pipe_vld    <= '0;
        outstanding <= '0;
      end else begin
        pipe_vld[0] <= accept;
        for (int i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
        // Accept and ack in the same cycle leave the count unchanged.
        case ({accept, ack})
          2'b10:   outstanding <= outstanding + CNT_W'(1);
          2'b01:   outstanding <= outstanding - CNT_W'(1);
          default: outstanding <= outstanding;
        endcase
      end
    end
  end

  if (STALL_RATE == 0) begin : g_no_rnd_stall
    assign rnd_stall = 1'b0;
  end else begin : g_rnd_stall
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) rnd_stall <= 1'b0;
      else        rnd_stall <= (lfsr[3:0] < 4'(STALL_RATE));
    end
  end

endmodule

// File: tb/tb_wb_pipe_responder.sv
// Self-checking bench for wb_pipe_responder. Four instances cover different
// parameter sets:
//   u0: LATENCY 2, DEPTH 4, no random stall  (read-after-write, byte enables, wrap)
//   u1: LATENCY 4, DEPTH 2, no random stall  (depth stall, cyc_i drop)
//   u2: LATENCY 4, DEPTH 4, STALL_RATE 8     (1000-request scoreboard run)
//   u3: LATENCY 4, DEPTH 4, no random stall  (reset with requests in flight)
// Drivers push the expected response when a request is accepted; a per-DUT
// monitor pops and compares on every ack.
module tb_wb_pipe_responder;

  localparam int N = 4;
  localparam int LAT_P [N] = '{2, 4, 4, 4};
  localparam int DEP_P [N] = '{4, 2, 4, 4};
  localparam int STR_P [N] = '{0, 0, 8, 0};

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc_cnt = 0;
  int   errors  = 0;
  int   checks  = 0;

  logic [31:0] addr_d [N];
  logic [31:0] wdat_d [N];
  logic [3:0]  sel_d  [N];
  logic        we_d   [N];
  logic        stb_d  [N];
  logic        cyc_d  [N];
  logic [N-1:0] stall_w;
  logic [N-1:0] ack_w;
  logic [31:0] data_w [N];

  exp_t exp_q [N][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_pipe_responder_if bus_if [N] ();

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign bus_if[g].addr_i = addr_d[g];
    assign bus_if[g].data_i = wdat_d[g];
    assign bus_if[g].sel_i  = sel_d[g];
    assign bus_if[g].we_i   = we_d[g];
    assign bus_if[g].stb_i  = stb_d[g];
    assign bus_if[g].cyc_i  = cyc_d[g];
    assign stall_w[g] = bus_if[g].stall_o;
    assign ack_w[g]   = bus_if[g].ack_o;
    assign data_w[g]  = bus_if[g].data_o;

    wb_pipe_responder #(
      .ADDR_W     (10),
      .LATENCY    (LAT_P[g]),
      .DEPTH      (DEP_P[g]),
      .STALL_RATE (STR_P[g]),
      .LFSR_SEED  (16'hACE1)
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus_if[g])
    );

    always @(negedge clk) monitor(g);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor(input int i);
    exp_t e;
    if (!rst_n) begin
      check($sformatf("u%0d.rst_ack", i), 32'(ack_w[i]), 32'h0);
      check($sformatf("u%0d.rst_data", i), data_w[i], 32'h0);
      check($sformatf("u%0d.rst_stall", i), 32'(stall_w[i]), 32'h0);
      exp_q[i].delete();
    end else if (!cyc_d[i]) begin
      check($sformatf("u%0d.nocyc_ack", i), 32'(ack_w[i]), 32'h0);
      exp_q[i].delete();
    end else if (ack_w[i]) begin
      check($sformatf("u%0d.ack_pending", i), 32'(exp_q[i].size() != 0), 32'h1);
      if (exp_q[i].size() != 0) begin
        e = exp_q[i].pop_front();
        check($sformatf("u%0d.ack_latency", i), 32'(cyc_cnt - e.acc), 32'(LAT_P[i]));
        check($sformatf("u%0d.ack_data", i), data_w[i], e.data);
      end
    end else begin
      check($sformatf("u%0d.idle_data", i), data_w[i], 32'h0);
    end
  endtask

  // Called just after a rising edge; holds the request until accepted and
  // returns one cycle later, leaving stb low unless the next call raises it.
  task automatic issue(input int i, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] sel,
                       input logic [31:0] exp, output int acc);
    int   waited;
    exp_t e;
    waited = 0;
    cyc_d[i]  = 1'b1;
    stb_d[i]  = 1'b1;
    we_d[i]   = we;
    addr_d[i] = addr;
    wdat_d[i] = data;
    sel_d[i]  = sel;
    @(negedge clk);
    while (stall_w[i] && waited < 64) begin
      waited++;
      @(negedge clk);
    end
    check($sformatf("u%0d.accept_in_time", i), 32'(stall_w[i]), 32'h0);
    acc = cyc_cnt;
    if (!stall_w[i]) begin
      e.data = we ? 32'h0 : exp;
      e.acc  = cyc_cnt;
      exp_q[i].push_back(e);
    end
    @(posedge clk);
    #1;
    stb_d[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (exp_q[i].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d.drained", i), 32'(exp_q[i].size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          acc, c0, c1, c2, c3;
    int          w;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] mdl [16];

    for (int i = 0; i < N; i++) begin
      addr_d[i] = '0; wdat_d[i] = '0; sel_d[i] = '0;
      we_d[i] = 1'b0; stb_d[i] = 1'b0; cyc_d[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // u0: write then immediate read, byte-enable merge, empty sel, wrap.
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, acc);
    issue(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, acc);
    issue(0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0, acc);
    issue(0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0, acc);
    issue(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'h11BB_33DD, acc);
    issue(0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 32'h0, acc);
    issue(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 32'h11BB_33DD, acc);
    issue(0, 1'b0, 32'hFFFF_F013, 32'h0, 4'hF, 32'hDEAD_BEEF, acc);
    issue(0, 1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 4'hF, 32'h0, acc);
    issue(0, 1'b0, 32'h0000_1FFC, 32'h0, 4'hF, 32'h0BAD_CAFE, acc);
    drain(0);
    cyc_d[0] = 1'b0;

    // u1: preload, then held-strobe reads against DEPTH 2 / LATENCY 4.
    for (int k = 0; k < 4; k++)
      issue(1, 1'b1, 32'(k * 4), 32'hB000_0000 + 32'(k), 4'hF, 32'h0, acc);
    drain(1);
    issue(1, 1'b0, 32'h0, 32'h0, 4'hF, 32'hB000_0000, c0);
    issue(1, 1'b0, 32'h4, 32'h0, 4'hF, 32'hB000_0001, c1);
    issue(1, 1'b0, 32'h8, 32'h0, 4'hF, 32'hB000_0002, c2);
    issue(1, 1'b0, 32'hC, 32'h0, 4'hF, 32'hB000_0003, c3);
    check("u1.accept2_gap", 32'(c1 - c0), 32'd1);
    check("u1.accept3_gap", 32'(c2 - c0), 32'd5);
    check("u1.accept4_gap", 32'(c3 - c0), 32'd6);
    drain(1);

    // u1: drop cyc_i with two reads in flight.
    issue(1, 1'b0, 32'h0, 32'h0, 4'hF, 32'hB000_0000, acc);
    issue(1, 1'b0, 32'h4, 32'h0, 4'hF, 32'hB000_0001, acc);
    cyc_d[1] = 1'b0;
    @(negedge clk);
    check("u1.drop_stall_full", 32'(stall_w[1]), 32'h1);
    @(posedge clk);
    #1 cyc_d[1] = 1'b1;
    @(negedge clk);
    check("u1.drop_cnt_clear", 32'(stall_w[1]), 32'h0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    issue(1, 1'b0, 32'h8, 32'h0, 4'hF, 32'hB000_0002, acc);
    issue(1, 1'b1, 32'h4, 32'h1234_5678, 4'b1000, 32'h0, acc);
    issue(1, 1'b0, 32'h4, 32'h0, 4'hF, 32'h1200_0001, acc);
    drain(1);
    cyc_d[1] = 1'b0;

    // u2: 1000 back-to-back requests with random stalls.
    for (int k = 0; k < 16; k++) begin
      d = 32'h0F1E_2D3C ^ (32'(k) * 32'h0101_0101);
      issue(2, 1'b1, 32'(k * 4), d, 4'hF, 32'h0, acc);
      mdl[k] = d;
    end
    for (int j = 0; j < 984; j++) begin
      w = (j * 7 + 3) % 16;
      d = 32'(j) * 32'h9E37_79B9;
      s = 4'((j * 5 + 1) % 16);
      if ((j % 3) != 0) begin
        issue(2, 1'b1, 32'(w * 4), d, s, 32'h0, acc);
        for (int b = 0; b < 4; b++) if (s[b]) mdl[w][8*b +: 8] = d[8*b +: 8];
      end else begin
        issue(2, 1'b0, 32'(w * 4) | (32'(j) << 12) | 32'(j % 4), 32'h0, 4'hF, mdl[w], acc);
      end
    end
    drain(2);
    cyc_d[2] = 1'b0;

    // u3: reset pulse with three requests outstanding.
    issue(3, 1'b1, 32'h14, 32'h5555_AAAA, 4'hF, 32'h0, acc);
    drain(3);
    issue(3, 1'b0, 32'h14, 32'h0, 4'hF, 32'h5555_AAAA, acc);
    issue(3, 1'b0, 32'h14, 32'h0, 4'hF, 32'h5555_AAAA, acc);
    issue(3, 1'b0, 32'h14, 32'h0, 4'hF, 32'h5555_AAAA, acc);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    issue(3, 1'b1, 32'h18, 32'h600D_F00D, 4'hF, 32'h0, acc);
    issue(3, 1'b0, 32'h18, 32'h0, 4'hF, 32'h600D_F00D, acc);
    drain(3);
    cyc_d[3] = 1'b0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_pipe_responder.md
WB_PIPE_RESPONDER -- requirements
Module: wb_pipe_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width, giving 2^ADDR_W x 32-bit memory.
REQ-002 SHALL have parameter LATENCY, default 2, meaning accept-to-ack latency in cycles (legal 1..8).
REQ-003 SHALL have parameter DEPTH, default 4, meaning maximum outstanding accepted-but-unacked requests (legal 1..8).
REQ-004 SHALL have parameter STALL_RATE, default 0, meaning random stall threshold (0..15); 0 disables random stalls.
REQ-005 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning stall LFSR reset value (non-zero).
REQ-006 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port addr_i, input, 32, byte address; bits [ADDR_W+1:2] index memory, others ignored.
REQ-009 SHALL have port data_i, input, 32, write data.
REQ-010 SHALL have port sel_i, input, 4, byte enables; bit n enables data_i[8n+7:8n].
REQ-011 SHALL have port we_i, input, 1, 1 = write, 0 = read.
REQ-012 SHALL have port stb_i, input, 1, request strobe.
REQ-013 SHALL have port cyc_i, input, 1, bus cycle active.
REQ-014 SHALL have port stall_o, output, 1, request not accepted this cycle.
REQ-015 SHALL have port ack_o, output, 1, one-cycle response per accepted request.
REQ-016 SHALL have port data_o, output, 32, read data, valid when ack_o=1.

Function
REQ-017 SHALL accept a request in a cycle where cyc_i=1, stb_i=1, stall_o=0; one request per cycle max.
REQ-018 SHALL commit accepted writes to memory at the accept edge, honouring sel_i; unselected bytes unchanged.
REQ-019 SHALL read memory at the accept edge, so a read accepted the cycle after a write to the same word returns the new data.
REQ-020 SHALL carry each accepted request (valid, read data) through a LATENCY-stage shift pipeline; ack_o = final-stage valid.
REQ-021 SHALL assert ack_o exactly LATENCY cycles after the accept edge, in request order, one cycle per request, for reads and writes.
REQ-022 SHALL drive data_o with read data on read acks, 32'h0 on write acks and when ack_o=0.
REQ-023 SHALL keep an outstanding counter (0..DEPTH): +1 on accept, -1 on ack, net 0 when both occur the same cycle.
REQ-024 SHALL assert stall_o when outstanding == DEPTH, or when random stall is set; stall_o is independent of stb_i.
REQ-025 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle; random stall register <= (lfsr[3:0] < STALL_RATE).
REQ-026 SHALL, when cyc_i=0, clear all pipeline valids and the outstanding counter next edge; no ack_o for dropped requests; committed writes stay.
REQ-027 SHALL never assert ack_o in a cycle where cyc_i=0.
REQ-028 SHALL wrap addresses modulo 2^ADDR_W words; no error response.

Reset
REQ-029 SHALL, while rst_i=0, force ack_o=0, data_o=0, stall_o=0, pipeline valids=0, counter=0, lfsr=LFSR_SEED, random stall=0.
REQ-030 SHALL not reset memory contents (undefined until written).
REQ-031 SHALL, on reset assertion mid-transaction, discard all in-flight requests with no ack after release.

Verification
REQ-032 LATENCY=2: write 32'hDEADBEEF to 0x10 (sel 4'hF), then read 0x10 -> acks at accept+2 each, read data_o=32'hDEADBEEF.
REQ-033 Write 32'h11223344 to 0x20, then write 32'hAABBCCDD with sel 4'b0101, then read -> data_o=32'h11BB33DD.
REQ-034 DEPTH=2, LATENCY=4, stb_i held 1 -> stall_o=1 after 2 accepts until first ack; never more than 2 outstanding.
REQ-035 Drop cyc_i with 2 reads in flight -> no ack_o, counter 0 next cycle; new cycle after that acks normally.
REQ-036 STALL_RATE=8, 1000 back-to-back requests against a scoreboard -> every accept acked once in order, all read data matches.
REQ-037 Pulse rst_i low with 3 requests outstanding -> all outputs 0 during reset, no stale ack afterward.
